// File: rtl/shift_count_register.sv
// shift_count_register: parametrised load/clear/count/shift register.
// Multi-bit serial shifts run one bit per clock with a busy/done handshake;
// carry reports the last bit shifted out or an inc/dec overflow.
module shift_count_register #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 4,
    parameter int SAT         = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cl,
    input  logic                   ld,
    input  logic [DATA_WIDTH-1:0]  in,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   sr,
    input  logic                   sl,
    input  logic                   il,
    input  logic                   ir,
    input  logic                   arith,
    input  logic                   rot,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  out,
    output logic                   carry,
    output logic                   zero,
    output logic                   busy,
    output logic                   done
);

    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   right_q, right_d;
    logic                   arith_q, arith_d;
    logic                   rot_q, rot_d;
    logic                   ser_q, ser_d;

    logic                   step_right;
    logic                   step_arith;
    logic                   step_rot;
    logic                   step_ser;
    logic                   fill;
    logic [DATA_WIDTH-1:0]  step_out;
    logic                   step_carry;

    // One-bit shift step: live command inputs on the command edge, latched ones afterwards.
    always_comb begin
        step_right = right_q;
        step_arith = arith_q;
        step_rot   = rot_q;
        step_ser   = ser_q;
        if (state_q == IDLE) begin
            step_right = sr;
            step_arith = arith;
            step_rot   = rot;
            step_ser   = sr ? il : ir;
        end
        if (step_right) begin
            fill       = step_rot ? out_q[0] : (step_arith ? out_q[MSB] : step_ser);
            step_out   = {fill, out_q[MSB:1]};
            step_carry = out_q[0];
        end else begin
            fill       = step_rot ? out_q[MSB] : step_ser;
            step_out   = {out_q[MSB-1:0], fill};
            step_carry = out_q[MSB];
        end
    end

    // Next-state and next-register logic: command decode in IDLE, stepping/abort in SHIFT.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        right_d = right_q;
        arith_d = arith_q;
        rot_d   = rot_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end else if (ld) begin
                    out_d   = in;
                    carry_d = 1'b0;
                end else if (inc) begin
                    if (&out_q) begin
                        carry_d = 1'b1;
                        out_d   = (SAT != 0) ? out_q : '0;
                    end else begin
                        carry_d = 1'b0;
                        out_d   = out_q + 1'b1;
                    end
                end else if (dec) begin
                    if (out_q == '0) begin
                        carry_d = 1'b1;
                        out_d   = (SAT != 0) ? out_q : '1;
                    end else begin
                        carry_d = 1'b0;
                        out_d   = out_q - 1'b1;
                    end
                end else if (sr || sl) begin
                    right_d = sr;
                    arith_d = arith;
                    rot_d   = rot;
                    ser_d   = sr ? il : ir;
                    if (shamt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        out_d   = step_out;
                        carry_d = step_carry;
                        if (shamt == SHAMT_WIDTH'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            cnt_d   = shamt - 1'b1;
                        end
                    end
                end
            end
            SHIFT: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    out_d   = step_out;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that also cancels any shift in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
            rot_q   <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            arith_q <= arith_d;
            rot_q   <= rot_d;
            ser_q   <= ser_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;

endmodule

// File: tb/tb_shift_count_register.sv
// Testbench for shift_count_register: a wrapping and a saturating instance
// share stimulus; expectations come from an arithmetic reference model.
module tb_shift_count_register;

    localparam int W = 16;
    localparam logic [W-1:0] ONES = '1;

    logic         clk;
    logic         rst, cl, ld, inc, dec, sr, sl, il, ir, arith, rot;
    logic [W-1:0] din;
    logic [3:0]   shamt;
    logic [W-1:0] out_w, out_s;
    logic         carry_w, zero_w, busy_w, done_w;
    logic         carry_s, zero_s, busy_s, done_s;

    int tests_run = 0;
    int failures  = 0;

    shift_count_register #(.DATA_WIDTH(W), .SHAMT_WIDTH(4), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .il(il), .ir(ir), .arith(arith), .rot(rot), .shamt(shamt),
        .out(out_w), .carry(carry_w), .zero(zero_w), .busy(busy_w), .done(done_w)
    );

    shift_count_register #(.DATA_WIDTH(W), .SHAMT_WIDTH(4), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .il(il), .ir(ir), .arith(arith), .rot(rot), .shamt(shamt),
        .out(out_s), .carry(carry_s), .zero(zero_s), .busy(busy_s), .done(done_s)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single-cycle command result as {carry, out}.
    function automatic logic [W:0] ref_cmd(input logic [W-1:0] v, input logic c, input bit sat,
                                           input bit icl, input bit ild, input bit iinc,
                                           input bit idec, input logic [W-1:0] d);
        if (icl)  return {1'b0, {W{1'b0}}};
        if (ild)  return {1'b0, d};
        if (iinc) return (v == ONES) ? {1'b1, (sat ? ONES : {W{1'b0}})} : {1'b0, v + 16'd1};
        if (idec) return (v == '0)   ? {1'b1, (sat ? {W{1'b0}} : ONES)} : {1'b0, v - 16'd1};
        return {c, v};
    endfunction

    // Whole k-bit shift computed in one go as {carry, out}.
    function automatic logic [W:0] ref_shift(input logic [W-1:0] v, input logic c, input bit right,
                                             input bit ar, input bit ro, input bit ser, input int k);
        logic [W-1:0] r;
        logic         co;
        if (k == 0) return {c, v};
        if (right) begin
            co = v[k-1];
            if (ro)      r = (v >> k) | (v << (W - k));
            else if (ar) r = $signed(v) >>> k;
            else         r = (v >> k) | (ser ? ~(ONES >> k) : {W{1'b0}});
        end else begin
            co = v[W-k];
            if (ro) r = (v << k) | (v >> (W - k));
            else    r = (v << k) | (ser ? ~(ONES << k) : {W{1'b0}});
        end
        return {co, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
        il = 0; ir = 0; arith = 0; rot = 0; shamt = '0; din = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        ld = 1; din = v;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; ld = 1; din = 16'hBEEF;
        tick();
        clear_inputs();
        tests_run++;
        if ({out_w, carry_w, zero_w, busy_w, done_w} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_w: got out=%h c=%b z=%b busy=%b done=%b, expected 0000 0 1 0 0",
                     out_w, carry_w, zero_w, busy_w, done_w);
        end
        tests_run++;
        if ({out_s, carry_s, zero_s, busy_s, done_s} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_s: got out=%h c=%b z=%b busy=%b done=%b, expected 0000 0 1 0 0",
                     out_s, carry_s, zero_s, busy_s, done_s);
        end
    endtask

    task automatic test_load_priority();
        load(16'hA5A5);
        tests_run++;
        if ({out_w, carry_w, zero_w} !== {16'hA5A5, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL load: got out=%h c=%b z=%b, expected a5a5 0 0", out_w, carry_w, zero_w);
        end
        ld = 1; inc = 1; dec = 1; din = 16'h0003;
        tick(); clear_inputs();
        tests_run++;
        if (out_w !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL prio_ld: got out=%h, expected 0003", out_w);
        end
        cl = 1; ld = 1; inc = 1; din = 16'h7777;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, zero_w} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("[TB] FAIL prio_cl: got out=%h z=%b, expected 0000 1", out_w, zero_w);
        end
        inc = 1; dec = 1;
        tick(); clear_inputs();
        tests_run++;
        if (out_w !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL prio_inc: got out=%h, expected 0001", out_w);
        end
        dec = 1; sr = 1; shamt = 4'd5;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, busy_w, done_w} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL prio_dec: got out=%h c=%b busy=%b done=%b, expected 0000 0 0 0",
                     out_w, carry_w, busy_w, done_w);
        end
        sr = 1; sl = 1; il = 1; ir = 0; shamt = 4'd1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, busy_w, done_w} !== {16'h8000, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL prio_sr: got out=%h busy=%b done=%b, expected 8000 0 1", out_w, busy_w, done_w);
        end
    endtask

    task automatic test_count_bounds();
        load(16'hFFFF);
        inc = 1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, zero_w} !== {16'h0000, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL inc_wrap: got out=%h c=%b z=%b, expected 0000 1 1", out_w, carry_w, zero_w);
        end
        tests_run++;
        if ({out_s, carry_s} !== {16'hFFFF, 1'b1}) begin
            failures++;
            $display("[TB] FAIL inc_sat: got out=%h c=%b, expected ffff 1", out_s, carry_s);
        end
        dec = 1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w} !== {16'hFFFF, 1'b1}) begin
            failures++;
            $display("[TB] FAIL dec_wrap: got out=%h c=%b, expected ffff 1", out_w, carry_w);
        end
        tests_run++;
        if ({out_s, carry_s} !== {16'hFFFE, 1'b0}) begin
            failures++;
            $display("[TB] FAIL dec_sat_mid: got out=%h c=%b, expected fffe 0", out_s, carry_s);
        end
        load(16'h0000);
        dec = 1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_s, carry_s, zero_s} !== {16'h0000, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL dec_sat: got out=%h c=%b z=%b, expected 0000 1 1", out_s, carry_s, zero_s);
        end
        tick();
        tests_run++;
        if ({out_w, carry_w} !== {16'hFFFF, 1'b1}) begin
            failures++;
            $display("[TB] FAIL carry_hold: got out=%h c=%b, expected ffff 1", out_w, carry_w);
        end
    endtask

    task automatic test_edge_shamt();
        sr = 1; shamt = 4'd0; il = 0;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, busy_w, done_w} !== {16'hFFFF, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL shamt0: got out=%h c=%b busy=%b done=%b, expected ffff 1 0 1",
                     out_w, carry_w, busy_w, done_w);
        end
        tick();
        tests_run++;
        if ({out_w, busy_w, done_w} !== {16'hFFFF, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL shamt0_after: got out=%h busy=%b done=%b, expected ffff 0 0", out_w, busy_w, done_w);
        end
        load(16'h0000);
        sl = 1; ir = 1; shamt = 4'd1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, busy_w, done_w} !== {16'h0001, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL shamt1: got out=%h c=%b busy=%b done=%b, expected 0001 0 0 1",
                     out_w, carry_w, busy_w, done_w);
        end
        tick();
        tests_run++;
        if (done_w !== 1'b0) begin
            failures++;
            $display("[TB] FAIL shamt1_after: got done=%b, expected 0", done_w);
        end
    endtask

    task automatic test_arith_shift();
        load(16'h8010);
        sr = 1; arith = 1; il = 0; shamt = 4'd4;
        tick(); clear_inputs();
        for (int c = 1; c <= 4; c++) begin
            tests_run++;
            if ({busy_w, done_w} !== {(c < 4), (c == 4)}) begin
                failures++;
                $display("[TB] FAIL arith_hs c=%0d: got busy=%b done=%b, expected %b %b",
                         c, busy_w, done_w, (c < 4), (c == 4));
            end
            if (c < 4) tick();
        end
        tests_run++;
        if ({out_w, carry_w} !== {16'hF801, 1'b0}) begin
            failures++;
            $display("[TB] FAIL arith_val: got out=%h c=%b, expected f801 0", out_w, carry_w);
        end
        tick();
        tests_run++;
        if (done_w !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arith_done_pulse: got done=%b, expected 0", done_w);
        end
    endtask

    task automatic test_rotate();
        load(16'hE001);
        sl = 1; rot = 1; ir = 0; shamt = 4'd3;
        tick(); clear_inputs();
        for (int c = 1; c <= 3; c++) begin
            tests_run++;
            if ({busy_w, done_w} !== {(c < 3), (c == 3)}) begin
                failures++;
                $display("[TB] FAIL rot_hs c=%0d: got busy=%b done=%b, expected %b %b",
                         c, busy_w, done_w, (c < 3), (c == 3));
            end
            if (c < 3) tick();
        end
        tests_run++;
        if ({out_w, carry_w} !== {16'h000F, 1'b1}) begin
            failures++;
            $display("[TB] FAIL rot_val: got out=%h c=%b, expected 000f 1", out_w, carry_w);
        end
    endtask

    task automatic test_abort();
        logic [W:0] exp;
        int         bad;
        load(16'hF0F0);
        sr = 1; il = 1; shamt = 4'd15;
        tick(); clear_inputs();
        ld = 1; din = 16'h1234;
        tick(); clear_inputs();
        exp = ref_shift(16'hF0F0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        tests_run++;
        if ({carry_w, out_w, busy_w} !== {exp, 1'b1}) begin
            failures++;
            $display("[TB] FAIL abort_ld_ignored: got c=%b out=%h busy=%b, expected %b %h 1",
                     carry_w, out_w, busy_w, exp[W], exp[W-1:0]);
        end
        tick(); tick();
        cl = 1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, zero_w, busy_w, done_w} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_cl: got out=%h c=%b z=%b busy=%b done=%b, expected 0000 0 1 0 0",
                     out_w, carry_w, zero_w, busy_w, done_w);
        end
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (done_w || busy_w) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL abort_cl_quiet: got %0d cycles with busy/done, expected 0", bad);
        end
        load(16'hF0F0);
        sr = 1; il = 1; shamt = 4'd15;
        tick(); clear_inputs();
        tick(); tick(); tick();
        rst = 1;
        tick(); clear_inputs();
        tests_run++;
        if ({out_w, carry_w, zero_w, busy_w, done_w} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_rst: got out=%h c=%b z=%b busy=%b done=%b, expected 0000 0 1 0 0",
                     out_w, carry_w, zero_w, busy_w, done_w);
        end
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (done_w || busy_w) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL abort_rst_quiet: got %0d cycles with busy/done, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] e1, e2;
        load(16'h1234);
        sl = 1; rot = 1; shamt = 4'd2;
        tick(); clear_inputs();
        tick();
        e1 = ref_shift(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        tests_run++;
        if ({carry_w, out_w, busy_w, done_w} !== {e1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL b2b_first: got c=%b out=%h busy=%b done=%b, expected %b %h 0 1",
                     carry_w, out_w, busy_w, done_w, e1[W], e1[W-1:0]);
        end
        sr = 1; il = 1; shamt = 4'd1;
        tick(); clear_inputs();
        e2 = ref_shift(e1[W-1:0], e1[W], 1'b1, 1'b0, 1'b0, 1'b1, 1);
        tests_run++;
        if ({carry_w, out_w, busy_w, done_w} !== {e2, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL b2b_second: got c=%b out=%h busy=%b done=%b, expected %b %h 0 1",
                     carry_w, out_w, busy_w, done_w, e2[W], e2[W-1:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] mw, ms;
        logic         cw, cs;
        logic [W:0]   ew, es;
        bit           rcl, rld, rinc, rdec, rsr, rsl, is_shift;
        int           k, done_at, busy_cnt, overlap, exp_done;
        mw = 16'h5A3C; ms = 16'h5A3C; cw = 0; cs = 0;
        load(16'h5A3C);
        for (int it = 0; it < 150; it++) begin
            rcl  = ($urandom_range(0, 11) == 0);
            rld  = ($urandom_range(0, 4) == 0);
            rinc = ($urandom_range(0, 3) == 0);
            rdec = ($urandom_range(0, 3) == 0);
            rsr  = ($urandom_range(0, 1) == 0);
            rsl  = ($urandom_range(0, 1) == 0);
            k    = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) din = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
            else din = 16'($urandom);
            cl = rcl; ld = rld; inc = rinc; dec = rdec; sr = rsr; sl = rsl;
            il = 1'($urandom); ir = 1'($urandom); arith = 1'($urandom); rot = 1'($urandom);
            shamt = 4'(k);
            is_shift = !rcl && !rld && !rinc && !rdec && (rsr || rsl);
            if (!is_shift) begin
                ew = ref_cmd(mw, cw, 1'b0, rcl, rld, rinc, rdec, din);
                es = ref_cmd(ms, cs, 1'b1, rcl, rld, rinc, rdec, din);
                tick(); clear_inputs();
                tests_run++;
                if ({carry_w, out_w, zero_w, busy_w, done_w, carry_s, out_s, zero_s, busy_s, done_s} !==
                    {ew, (ew[W-1:0] == '0), 2'b00, es, (es[W-1:0] == '0), 2'b00}) begin
                    failures++;
                    $display("[TB] FAIL rand_cmd it=%0d: got w=%b/%h z=%b b=%b d=%b s=%b/%h, expected w=%b/%h s=%b/%h",
                             it, carry_w, out_w, zero_w, busy_w, done_w, carry_s, out_s,
                             ew[W], ew[W-1:0], es[W], es[W-1:0]);
                end
            end else begin
                ew = ref_shift(mw, cw, rsr, arith, rot, rsr ? il : ir, k);
                es = ref_shift(ms, cs, rsr, arith, rot, rsr ? il : ir, k);
                tick(); clear_inputs();
                done_at = 0; busy_cnt = 0; overlap = 0;
                for (int t = 1; t <= 20 && done_at == 0; t++) begin
                    if (busy_w && done_w) overlap++;
                    if (done_w) done_at = t;
                    else begin
                        if (busy_w) busy_cnt++;
                        tick();
                    end
                end
                exp_done = (k == 0) ? 1 : k;
                tests_run++;
                if (done_at !== exp_done || busy_cnt !== exp_done - 1 || overlap !== 0) begin
                    failures++;
                    $display("[TB] FAIL rand_shift_timing it=%0d k=%0d: got done_at=%0d busy=%0d overlap=%0d, expected %0d %0d 0",
                             it, k, done_at, busy_cnt, overlap, exp_done, exp_done - 1);
                end
                tests_run++;
                if ({carry_w, out_w, zero_w, carry_s, out_s} !== {ew, (ew[W-1:0] == '0), es}) begin
                    failures++;
                    $display("[TB] FAIL rand_shift_val it=%0d k=%0d: got w=%b/%h s=%b/%h, expected w=%b/%h s=%b/%h",
                             it, k, carry_w, out_w, carry_s, out_s, ew[W], ew[W-1:0], es[W], es[W-1:0]);
                end
            end
            cw = ew[W]; mw = ew[W-1:0];
            cs = es[W]; ms = es[W-1:0];
        end
    endtask

    // Scenario sequence.
    initial begin
        clear_inputs();
        test_reset();
        test_load_priority();
        test_count_bounds();
        test_edge_shamt();
        test_arith_shift();
        test_rotate();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
